// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared constants, frame-word layout and reader state encoding for the vector display path
package vector_pkg;

    localparam int DAC_WIDTH    = 8;
    localparam int ADDRESSWIDTH = 10;

    // Frame word layout: {eof, blank, x, y}; positions scale with the DAC width
    function automatic int f_y_lsb(input int out_w);
        return 0;
    endfunction

    function automatic int f_x_lsb(input int out_w);
        return out_w;
    endfunction

    function automatic int f_blank_bit(input int out_w);
        return 2 * out_w;
    endfunction

    function automatic int f_eof_bit(input int out_w);
        return 2 * out_w + 1;
    endfunction

    localparam int Y_LSB     = 0;
    localparam int X_LSB     = DAC_WIDTH;
    localparam int BLANK_BIT = 2 * DAC_WIDTH;
    localparam int EOF_BIT   = 2 * DAC_WIDTH + 1;

    localparam logic [DAC_WIDTH-1:0] DAC_MID = {1'b1, {(DAC_WIDTH-1){1'b0}}};

    typedef logic [2:0] rdr_state_t;

    localparam rdr_state_t ST_IDLE    = 3'd0;
    localparam rdr_state_t ST_WAIT    = 3'd1;
    localparam rdr_state_t ST_LATCH   = 3'd2;
    localparam rdr_state_t ST_HOLD    = 3'd3;
    localparam rdr_state_t ST_ENDPASS = 3'd4;

endpackage

// File: rtl/vector_word_decode.sv
// rtl/vector_word_decode.sv - combinational split of a frame RAM word into eof, blank, x and y fields
module vector_word_decode
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH = DAC_WIDTH,
    parameter int DATAWIDTH = 2 * OUT_WIDTH + 2
) (
    input  logic [DATAWIDTH-1:0] i_data,
    output logic                 o_eof,
    output logic                 o_blank,
    output logic [OUT_WIDTH-1:0] o_x,
    output logic [OUT_WIDTH-1:0] o_y
);

    localparam int EOF_B   = f_eof_bit(OUT_WIDTH);
    localparam int BLANK_B = f_blank_bit(OUT_WIDTH);
    localparam int X_L     = f_x_lsb(OUT_WIDTH);
    localparam int Y_L     = f_y_lsb(OUT_WIDTH);

    assign o_eof   = i_data[EOF_B];
    assign o_blank = i_data[BLANK_B];
    assign o_x     = i_data[X_L +: OUT_WIDTH];
    assign o_y     = i_data[Y_L +: OUT_WIDTH];

endmodule

// File: rtl/vector_frame_reader.sv
// rtl/vector_frame_reader.sv - walks the frame RAM after go, drives X/Y DAC codes with per-point dwell and frame replay
module vector_frame_reader
    import vector_pkg::*;
#(
    parameter int ADR_WIDTH = ADDRESSWIDTH,
    parameter int DATAWIDTH = 2 * DAC_WIDTH + 2,
    parameter int OUT_WIDTH = DAC_WIDTH,
    parameter int DEPTH     = 100,
    parameter int DWELL     = 4,
    parameter int REFRESH   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    output logic                 halt,
    output logic [ADR_WIDTH-1:0] adrREAD,
    input  logic [DATAWIDTH-1:0] dataREAD,
    output logic [OUT_WIDTH-1:0] xout,
    output logic [OUT_WIDTH-1:0] yout,
    output logic                 blank,
    output logic                 frame_done,
    output logic [2:0]           state_debug
);

    localparam int DW_W = $clog2(DWELL);
    localparam int PS_W = $clog2(REFRESH + 1);

    localparam logic [ADR_WIDTH-1:0] LAST_ADR   = ADR_WIDTH'(DEPTH - 1);
    localparam logic [ADR_WIDTH-1:0] ADR_ONE    = ADR_WIDTH'(1);
    localparam logic [DW_W-1:0]      DWELL_LOAD = DW_W'(DWELL - 2);
    localparam logic [DW_W-1:0]      DWELL_ONE  = DW_W'(1);
    localparam logic [PS_W-1:0]      LAST_PASS  = PS_W'(REFRESH - 1);
    localparam logic [PS_W-1:0]      PASS_ONE   = PS_W'(1);
    localparam logic [OUT_WIDTH-1:0] MID        = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    rdr_state_t           r_state;
    logic                 r_halt;
    logic [ADR_WIDTH-1:0] r_adr;
    logic [OUT_WIDTH-1:0] r_x;
    logic [OUT_WIDTH-1:0] r_y;
    logic                 r_blank;
    logic                 r_frame_done;
    logic [PS_W-1:0]      r_pass;
    logic [DW_W-1:0]      r_dwell;
    logic                 r_last;

    logic                 w_eof;
    logic                 w_blank;
    logic [OUT_WIDTH-1:0] w_x;
    logic [OUT_WIDTH-1:0] w_y;

    vector_word_decode #(
        .OUT_WIDTH (OUT_WIDTH),
        .DATAWIDTH (DATAWIDTH)
    ) u_decode (
        .i_data  (dataREAD),
        .o_eof   (w_eof),
        .o_blank (w_blank),
        .o_x     (w_x),
        .o_y     (w_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_halt       <= 1'b0;
            r_adr        <= '0;
            r_x          <= MID;
            r_y          <= MID;
            r_blank      <= 1'b1;
            r_frame_done <= 1'b0;
            r_pass       <= '0;
            r_dwell      <= '0;
            r_last       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_halt  <= 1'b1;
                        r_adr   <= '0;
                        r_pass  <= '0;
                        r_last  <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    if (w_eof) begin
                        r_blank <= 1'b1;
                        r_state <= ST_ENDPASS;
                    end else begin
                        r_x     <= w_x;
                        r_y     <= w_y;
                        r_blank <= w_blank;
                        // Address parks on the last word so the read never wraps
                        if (r_adr == LAST_ADR) begin
                            r_last <= 1'b1;
                        end else begin
                            r_adr <= r_adr + ADR_ONE;
                        end
                        r_dwell <= DWELL_LOAD;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_dwell == '0) begin
                        r_state <= r_last ? ST_ENDPASS : ST_LATCH;
                    end else begin
                        r_dwell <= r_dwell - DWELL_ONE;
                    end
                end
                ST_ENDPASS: begin
                    r_blank <= 1'b1;
                    if (r_pass == LAST_PASS) begin
                        r_halt       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_pass  <= r_pass + PASS_ONE;
                        r_adr   <= '0;
                        r_last  <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign halt        = r_halt;
    assign adrREAD     = r_adr;
    assign xout        = r_x;
    assign yout        = r_y;
    assign blank       = r_blank;
    assign frame_done  = r_frame_done;
    assign state_debug = r_state;

endmodule

// File: tb/tb_vector_frame_reader.sv
// tb/tb_vector_frame_reader.sv - scoreboard bench for vector_frame_reader across default, short-depth and multi-refresh builds
module tb_vector_frame_reader;
    import vector_pkg::*;

    typedef struct {
        int         t;
        logic [7:0] x;
        logic [7:0] y;
    } pt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        go_v    [3];
    logic        halt_v  [3];
    logic [9:0]  adr_v   [3];
    logic [17:0] rd_v    [3];
    logic [7:0]  x_v     [3];
    logic [7:0]  y_v     [3];
    logic        blank_v [3];
    logic        fd_v    [3];
    logic [2:0]  st_v    [3];
    logic [17:0] ram     [1024];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   base = 0;
    int   sel = 0;
    bit   mon_on = 1'b0;
    int   fd_count = 0;
    int   fd_t = -1;
    int   halt_cnt = 0;
    int   max_adr = 0;
    pt_t  exp_q[$];
    pt_t  e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) rd_v[i] <= ram[adr_v[i]];
    end

    vector_frame_reader u_main (
        .clk(clk), .rst(rst), .go(go_v[0]), .halt(halt_v[0]), .adrREAD(adr_v[0]), .dataREAD(rd_v[0]),
        .xout(x_v[0]), .yout(y_v[0]), .blank(blank_v[0]), .frame_done(fd_v[0]), .state_debug(st_v[0])
    );

    vector_frame_reader #(.DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .go(go_v[1]), .halt(halt_v[1]), .adrREAD(adr_v[1]), .dataREAD(rd_v[1]),
        .xout(x_v[1]), .yout(y_v[1]), .blank(blank_v[1]), .frame_done(fd_v[1]), .state_debug(st_v[1])
    );

    vector_frame_reader #(.REFRESH(3)) u_r3 (
        .clk(clk), .rst(rst), .go(go_v[2]), .halt(halt_v[2]), .adrREAD(adr_v[2]), .dataREAD(rd_v[2]),
        .xout(x_v[2]), .yout(y_v[2]), .blank(blank_v[2]), .frame_done(fd_v[2]), .state_debug(st_v[2])
    );

    // Every visible (blank=0) sample must match the next expected point, including its cycle offset from go
    always @(negedge clk) begin
        if (rst && mon_on) begin
            if (blank_v[sel] === 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL point_extra t=%0d x=%0d y=%0d required=none", cyc - base, x_v[sel], y_v[sel]);
                end else begin
                    e = exp_q.pop_front();
                    if ((cyc - base) !== e.t || x_v[sel] !== e.x || y_v[sel] !== e.y) begin
                        errors++;
                        $display("FAIL point t=%0d x=%0d y=%0d required t=%0d x=%0d y=%0d",
                                 cyc - base, x_v[sel], y_v[sel], e.t, e.x, e.y);
                    end
                end
            end
            if (fd_v[sel] === 1'b1) begin
                fd_count++;
                fd_t = cyc - base;
            end
            if (halt_v[sel] === 1'b1) halt_cnt++;
            if (int'(adr_v[sel]) > max_adr) max_adr = int'(adr_v[sel]);
        end
    end

    function automatic logic [17:0] wd(input logic eof, input logic bl, input logic [7:0] x, input logic [7:0] y);
        return {eof, bl, x, y};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_point(input int t, input logic [7:0] x, input logic [7:0] y);
        for (int d = 0; d < 4; d++) exp_q.push_back('{t + d, x, y});
    endtask

    task automatic start(input int i);
        sel      = i;
        fd_count = 0;
        fd_t     = -1;
        halt_cnt = 0;
        max_adr  = 0;
        mon_on   = 1'b1;
    endtask

    task automatic pulse_go(input int i);
        base    = cyc + 1;
        go_v[i] = 1'b1;
        tick();
        go_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && fd_count == 0; i++) tick();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic load_two_points();
        ram[0] = wd(1'b0, 1'b0, 8'd10, 8'd20);
        ram[1] = wd(1'b0, 1'b0, 8'd200, 8'd53);
        ram[2] = wd(1'b1, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (halt_v[0] !== 1'b0 || blank_v[0] !== 1'b1 || x_v[0] !== DAC_MID || y_v[0] !== DAC_MID ||
            adr_v[0] !== 10'd0 || st_v[0] !== ST_IDLE || fd_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold halt=%0b blank=%0b x=%0d y=%0d adr=%0d st=%0d required 0 1 128 128 0 0",
                     halt_v[0], blank_v[0], x_v[0], y_v[0], adr_v[0], st_v[0]);
        end
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (halt_v[0] !== 1'b0 || blank_v[0] !== 1'b1 || x_v[0] !== 8'd128 || y_v[0] !== 8'd128 ||
                adr_v[0] !== 10'd0 || fd_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle c=%0d halt=%0b blank=%0b x=%0d y=%0d adr=%0d required 0 1 128 128 0",
                         c, halt_v[0], blank_v[0], x_v[0], y_v[0], adr_v[0]);
            end
        end
    endtask

    task automatic test_single_frame();
        load_two_points();
        expect_point(2, 8'd10, 8'd20);
        expect_point(6, 8'd200, 8'd53);
        start(0);
        pulse_go(0);
        checks++;
        if (halt_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL t2_halt_rise got=%0b required=1", halt_v[0]);
        end
        wait_done(100);
        checks++;
        if (fd_t !== 11 || fd_count !== 1) begin
            errors++;
            $display("FAIL t2_frame_done t=%0d count=%0d required t=11 count=1", fd_t, fd_count);
        end
        checks++;
        if (halt_cnt !== 11 || halt_v[0] !== 1'b0 || blank_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL t2_end halt_cycles=%0d halt=%0b blank=%0b required 11 0 1", halt_cnt, halt_v[0], blank_v[0]);
        end
        checks++;
        if (x_v[0] !== 8'd200 || y_v[0] !== 8'd53 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL t2_hold_last x=%0d y=%0d pending=%0d required 200 53 0", x_v[0], y_v[0], exp_q.size());
        end
    endtask

    task automatic test_empty_frame();
        ram[0] = wd(1'b1, 1'b0, 8'd77, 8'd88);
        start(0);
        pulse_go(0);
        wait_done(100);
        checks++;
        if (fd_t !== 3 || fd_count !== 1 || halt_cnt !== 3) begin
            errors++;
            $display("FAIL t3_empty fd_t=%0d count=%0d halt_cycles=%0d required 3 1 3", fd_t, fd_count, halt_cnt);
        end
        checks++;
        if (blank_v[0] !== 1'b1 || halt_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL t3_idle blank=%0b halt=%0b required 1 0", blank_v[0], halt_v[0]);
        end
    endtask

    task automatic test_depth_limit();
        ram[0] = wd(1'b0, 1'b0, 8'd1, 8'd2);
        ram[1] = wd(1'b0, 1'b1, 8'd3, 8'd4);
        ram[2] = wd(1'b0, 1'b0, 8'd255, 8'd0);
        ram[3] = wd(1'b0, 1'b0, 8'd7, 8'd8);
        ram[4] = wd(1'b0, 1'b0, 8'd99, 8'd99);
        expect_point(2, 8'd1, 8'd2);
        expect_point(10, 8'd255, 8'd0);
        expect_point(14, 8'd7, 8'd8);
        start(1);
        pulse_go(1);
        wait_done(100);
        checks++;
        if (max_adr !== 3) begin
            errors++;
            $display("FAIL t4_max_adr got=%0d required=3", max_adr);
        end
        checks++;
        if (fd_t !== 18 || fd_count !== 1 || halt_cnt !== 18 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL t4_end fd_t=%0d count=%0d halt_cycles=%0d pending=%0d required 18 1 18 0",
                     fd_t, fd_count, halt_cnt, exp_q.size());
        end
    endtask

    task automatic test_refresh();
        load_two_points();
        ram[3] = wd(1'b0, 1'b0, 8'd99, 8'd99);
        for (int p = 0; p < 3; p++) begin
            expect_point(2 + 11 * p, 8'd10, 8'd20);
            expect_point(6 + 11 * p, 8'd200, 8'd53);
        end
        start(2);
        pulse_go(2);
        wait_done(200);
        checks++;
        if (fd_t !== 33 || fd_count !== 1) begin
            errors++;
            $display("FAIL t5_frame_done t=%0d count=%0d required t=33 count=1", fd_t, fd_count);
        end
        checks++;
        if (halt_cnt !== 33 || exp_q.size() !== 0 || max_adr !== 2) begin
            errors++;
            $display("FAIL t5_end halt_cycles=%0d pending=%0d max_adr=%0d required 33 0 2", halt_cnt, exp_q.size(), max_adr);
        end
    endtask

    task automatic test_go_and_reset();
        load_two_points();
        expect_point(2, 8'd10, 8'd20);
        expect_point(6, 8'd200, 8'd53);
        start(0);
        pulse_go(0);
        for (int c = 0; c < 3; c++) tick();
        go_v[0] = 1'b1;
        tick();
        go_v[0] = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (exp_q.size() !== 2 || st_v[0] !== ST_HOLD) begin
            errors++;
            $display("FAIL t6_mid_hold pending=%0d state=%0d required 2 %0d", exp_q.size(), st_v[0], ST_HOLD);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (halt_v[0] !== 1'b0 || blank_v[0] !== 1'b1 || x_v[0] !== 8'd128 || y_v[0] !== 8'd128 ||
            adr_v[0] !== 10'd0 || st_v[0] !== ST_IDLE || fd_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL t6_async_reset halt=%0b blank=%0b x=%0d y=%0d adr=%0d st=%0d required 0 1 128 128 0 0",
                     halt_v[0], blank_v[0], x_v[0], y_v[0], adr_v[0], st_v[0]);
        end
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (fd_count !== 0 || halt_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL t6_no_done count=%0d halt=%0b required 0 0", fd_count, halt_v[0]);
        end
        expect_point(2, 8'd10, 8'd20);
        expect_point(6, 8'd200, 8'd53);
        start(0);
        pulse_go(0);
        checks++;
        if (adr_v[0] !== 10'd0 || halt_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL t6_restart adr=%0d halt=%0b required 0 1", adr_v[0], halt_v[0]);
        end
        wait_done(100);
        checks++;
        if (fd_t !== 11 || fd_count !== 1 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL t6_restart_done t=%0d count=%0d pending=%0d required 11 1 0", fd_t, fd_count, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) go_v[i] = 1'b0;
        for (int a = 0; a < 1024; a++) ram[a] = '0;
        test_reset();
        test_single_frame();
        test_empty_frame();
        test_depth_limit();
        test_refresh();
        test_go_and_reset();
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim_time=%0t required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
